// File: rtl/com_pkg.sv
`default_nettype none
// ============================================================================
// Module   : com_pkg
// Purpose  : Shared width defaults and state encodings for the com_port block.
// Revision : 1.0
// ============================================================================
package com_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 12;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LOAD   = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;
    localparam logic [1:0] ST_UNLOAD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/com_unload_pipe.sv
`default_nettype none
// ============================================================================
// Module   : com_unload_pipe
// Purpose  : Result-region read sequencer: address counter, synchronous-read
//            alignment stage and registered output word with done marking.
// Revision : 1.0
// ============================================================================
module com_unload_pipe
    import com_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] remaining;
    logic            empty_pend;
    logic            issue;
    logic            rd_valid;
    logic            rd_last;
    logic            rd_empty;

    assign issue = (remaining != '0);

    // Issue stage: one address per cycle until the requested count is spent.
    // A zero-length request still produces one marker slot through the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            remaining  <= '0;
            empty_pend <= 1'b0;
        end else if (start) begin
            addr       <= base;
            remaining  <= len;
            empty_pend <= (len == '0);
        end else begin
            empty_pend <= 1'b0;
            if (issue) begin
                addr      <= addr + ADDR_ONE;
                remaining <= remaining - CNT_ONE;
            end
        end
    end

    // Read stage: tracks the slot whose memory data lands on rdata next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_empty <= 1'b0;
        end else begin
            rd_valid <= issue | empty_pend;
            rd_last  <= empty_pend | (remaining == CNT_ONE);
            rd_empty <= empty_pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            last  <= 1'b0;
            data  <= '0;
        end else begin
            valid <= rd_valid;
            last  <= rd_valid & rd_last;
            data  <= (rd_valid && !rd_empty) ? rdata : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/com_port.sv
`default_nettype none
// ============================================================================
// Module   : com_port
// Purpose  : Host load / run / unload sequencer in front of a shared memory.
// Revision : 1.0
// ============================================================================
module com_port
    import com_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] com_data_in,
    input  logic              data_write_start,
    input  logic              data_write_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W:0]   out_len,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] com_data_out,
    output logic              output_write_start,
    output logic              output_write_done,
    output logic              load_overflow
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};

    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic              unload_go;
    logic [ADDR_W-1:0] unload_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // UNLOAD ends on the cycle that shows the final result word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (data_write_start)  state_nxt = ST_LOAD;
            ST_LOAD:   if (data_write_done)   state_nxt = ST_RUN;
            ST_RUN:    if (proc_done)         state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (output_write_done) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = ptr;
        unload_go = 1'b0;
        case (state)
            ST_LOAD: begin
                mem_we = !full;
                if (!full) begin
                    mem_wdata = com_data_in;
                end
            end
            ST_RUN:    unload_go = proc_done;
            ST_UNLOAD: mem_addr  = unload_addr;
            default:   ;
        endcase
    end

    // Load pointer saturates at the top address; overflow stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            full          <= 1'b0;
            load_overflow <= 1'b0;
            proc_start    <= 1'b0;
        end else begin
            proc_start <= (state == ST_LOAD) && data_write_done;
            if ((state == ST_IDLE) && data_write_start) begin
                ptr  <= '0;
                full <= 1'b0;
            end else if (state == ST_LOAD) begin
                if (full) begin
                    load_overflow <= 1'b1;
                end else if (ptr == PTR_MAX) begin
                    full <= 1'b1;
                end else begin
                    ptr <= ptr + ADDR_ONE;
                end
            end
        end
    end

    com_unload_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_unload (
        .clk   (clk),
        .rst_n (rst_n),
        .start (unload_go),
        .base  (out_base),
        .len   (out_len),
        .rdata (mem_rdata),
        .addr  (unload_addr),
        .data  (com_data_out),
        .valid (output_write_start),
        .last  (output_write_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_com_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_com_port
// Purpose  : Self-checking bench for com_port with a behavioural memory model.
// Revision : 1.0
// ============================================================================
module tb_com_port;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] com_data_in = '0;
    logic          data_write_start = 1'b0;
    logic          data_write_done = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          proc_start;
    logic          proc_done = 1'b0;
    logic [AW-1:0] out_base = '0;
    logic [AW:0]   out_len = '0;
    logic [1:0]    state;
    logic [DW-1:0] com_data_out;
    logic          output_write_start;
    logic          output_write_done;
    logic          load_overflow;

    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    logic          ovf_exp = 1'b0;
    int            checks = 0;
    int            errors = 0;

    com_port #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .com_data_in        (com_data_in),
        .data_write_start   (data_write_start),
        .data_write_done    (data_write_done),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .proc_start         (proc_start),
        .proc_done          (proc_done),
        .out_base           (out_base),
        .out_len            (out_len),
        .state              (state),
        .com_data_out       (com_data_out),
        .output_write_start (output_write_start),
        .output_write_done  (output_write_done),
        .load_overflow      (load_overflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read, synchronous-write memory seen by the DUT.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic do_load(input int n, input bit directed);
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        com_data_in      = 16'hDEAD;
        data_write_start = 1'b1;
        data_write_done  = 1'b0;
        #3;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_no_write: mem_we=%b expected 0", mem_we); end
        @(posedge clk); #1;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL enter_load: state=%0d expected 1", state); end
        for (int i = 0; i < n; i++) begin
            w = directed ? 16'((i + 1) * 10) : 16'($urandom);
            com_data_in      = w;
            data_write_done  = (i == n - 1);
            data_write_start = 1'($urandom_range(0, 1));
            if (i < DEPTH) ref_mem[i] = w;
            else ovf_exp = 1'b1;
            a = 3'(i);
            #3;
            if (i < DEPTH) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a, w}) begin
                    errors++;
                    $display("FAIL load_write[%0d]: we/addr/data=%b/%0d/%0h expected 1/%0d/%0h", i, mem_we, mem_addr, mem_wdata, a, w);
                end
            end else begin
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_drop[%0d]: mem_we=%b expected 0", i, mem_we); end
            end
            @(posedge clk); #1;
        end
        data_write_start = 1'b0;
        data_write_done  = 1'b0;
        com_data_in      = '0;
        checks++; if ({state, proc_start} !== {2'b10, 1'b1}) begin errors++; $display("FAIL run_entry: state/proc_start=%0d/%b expected 2/1", state, proc_start); end
        checks++; if (load_overflow !== ovf_exp) begin errors++; $display("FAIL overflow: got %b expected %b", load_overflow, ovf_exp); end
        for (int j = 0; j < DEPTH; j++) begin
            checks++; if (mem[j] !== ref_mem[j]) begin errors++; $display("FAIL mem[%0d]: got %0h expected %0h", j, mem[j], ref_mem[j]); end
        end
        @(posedge clk); #1;
        checks++; if ({state, proc_start} !== {2'b10, 1'b0}) begin errors++; $display("FAIL run_hold: state/proc_start=%0d/%b expected 2/0", state, proc_start); end
    endtask

    task automatic do_unload(input int base, input int len);
        int            w;
        logic [AW-1:0] a;
        logic [1:0]    e_state;
        logic          e_start, e_done;
        logic [DW-1:0] e_data;
        w        = (len == 0) ? 1 : len;
        out_base = 3'(base);
        out_len  = 4'(len);
        com_data_in      = 16'hBEEF;
        data_write_start = 1'b1;
        proc_done        = 1'b1;
        @(posedge clk); #1;
        proc_done        = 1'b0;
        data_write_start = 1'b0;
        for (int k = 0; k <= w + 2; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL unload_we k=%0d: mem_we=%b expected 0", k, mem_we); end
            if (k < len) begin
                a = 3'((base + k) % DEPTH);
                checks++; if (mem_addr !== a) begin errors++; $display("FAIL unload_addr k=%0d: got %0d expected %0d", k, mem_addr, a); end
            end
            if (k < w + 2) begin
                e_state = 2'b11;
                e_start = (k >= 2);
                e_done  = (k == w + 1);
                e_data  = (k >= 2 && len > 0) ? ref_mem[(base + k - 2) % DEPTH] : '0;
            end else begin
                e_state = 2'b00;
                e_start = 1'b0;
                e_done  = 1'b0;
                e_data  = '0;
            end
            checks++;
            if ({state, output_write_start, output_write_done} !== {e_state, e_start, e_done}) begin
                errors++;
                $display("FAIL unload_ctl k=%0d: state/start/done=%0d/%b/%b expected %0d/%b/%b", k, state, output_write_start, output_write_done, e_state, e_start, e_done);
            end
            checks++; if (com_data_out !== e_data) begin errors++; $display("FAIL unload_data k=%0d: got %0h expected %0h", k, com_data_out, e_data); end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, mem_we, mem_addr, mem_wdata, proc_start, com_data_out, output_write_start, output_write_done, load_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d we=%b addr=%0d wdata=%0h ps=%b out=%0h st=%b dn=%b ovf=%b expected all 0",
                     state, mem_we, mem_addr, mem_wdata, proc_start, com_data_out, output_write_start, output_write_done, load_overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_idle: state=%0d expected 0", state); end
    endtask

    task automatic test_directed;
        do_load(5, 1'b1);
        do_unload(2, 3);
    endtask

    task automatic test_zero_len;
        do_load(3, 1'b0);
        do_unload(0, 0);
    endtask

    task automatic test_wrap;
        do_load(8, 1'b0);
        do_unload(DEPTH - 1, 2);
    endtask

    task automatic test_overflow;
        do_load(10, 1'b0);
        do_unload(0, DEPTH);
    endtask

    task automatic test_reset_mid_unload;
        do_load(4, 1'b0);
        out_base  = '0;
        out_len   = 4'd4;
        proc_done = 1'b1;
        @(posedge clk); #1;
        proc_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({output_write_start, com_data_out} !== {1'b1, ref_mem[1]}) begin
            errors++;
            $display("FAIL mid_word2: start/data=%b/%0h expected 1/%0h", output_write_start, com_data_out, ref_mem[1]);
        end
        #2;
        rst_n = 1'b0;
        ovf_exp = 1'b0;
        #1;
        checks++;
        if ({state, mem_we, mem_addr, mem_wdata, proc_start, com_data_out, output_write_start, output_write_done, load_overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: state=%0d we=%b addr=%0d wdata=%0h ps=%b out=%0h st=%b dn=%b ovf=%b expected all 0",
                     state, mem_we, mem_addr, mem_wdata, proc_start, com_data_out, output_write_start, output_write_done, load_overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, output_write_start} !== 3'b000) begin
            errors++;
            $display("FAIL no_resume: state/start=%0d/%b expected 0/0", state, output_write_start);
        end
        do_load(6, 1'b0);
        do_unload(1, 5);
    endtask

    task automatic test_random;
        int n, b, l;
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 10);
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, DEPTH);
            do_load(n, 1'b0);
            do_unload(b, l);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_zero_len;
        test_wrap;
        test_overflow;
        test_reset_mid_unload;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
